// File: rtl/key_debounce.sv
// key_debounce: per-key 2-flop synchroniser and debounce FSM for active-low push-buttons.
// Auto-repeat pulses on key_repeat are built only when KEY_REPEAT_EN is defined.
module key_debounce #(
  parameter int unsigned KEY_W        = 4,
  parameter int unsigned DEB_CYCLES   = 1_000_000,
  parameter int unsigned REPEAT_DELAY = 25_000_000,
  parameter int unsigned REPEAT_RATE  = 5_000_000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [KEY_W-1:0] key,
  output logic [KEY_W-1:0] key_state,
  output logic [KEY_W-1:0] key_press,
  output logic [KEY_W-1:0] key_release,
  output logic [KEY_W-1:0] key_repeat
);

  localparam int unsigned MAX_DR  = (DEB_CYCLES > REPEAT_DELAY) ? DEB_CYCLES : REPEAT_DELAY;
  localparam int unsigned CNT_MAX = (MAX_DR > REPEAT_RATE) ? MAX_DR : REPEAT_RATE;
  localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);
  localparam logic [CNT_W-1:0] DEB_LAST = CNT_W'(DEB_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  typedef enum logic [1:0] {IDLE, PFILT, DOWN, RFILT} state_e;

  logic [KEY_W-1:0] s1, s2, p;
  state_e           state_q [KEY_W];
  state_e           state_d [KEY_W];
  logic [CNT_W-1:0] cnt_q   [KEY_W];
  logic [CNT_W-1:0] cnt_d   [KEY_W];
  logic [KEY_W-1:0] press_d, release_d, level_d;

`ifdef KEY_REPEAT_EN
  localparam logic [CNT_W-1:0] DLY_LAST  = CNT_W'(REPEAT_DELAY - 1);
  localparam logic [CNT_W-1:0] RATE_LAST = CNT_W'(REPEAT_RATE - 1);
  localparam logic [CNT_W-1:0] CNT_TOP   = CNT_W'(CNT_MAX);
  logic [KEY_W-1:0] rep_seen_q, rep_seen_d, rep_hit;
`endif

  // Synchroniser resets to "released" so reset never looks like a press.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1 <= '1;
      s2 <= '1;
    end else begin
      s1 <= key;
      s2 <= s1;
    end
  end

  assign p = ~s2;

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < KEY_W; i++) begin
        state_q[i] <= IDLE;
        cnt_q[i]   <= '0;
      end
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state logic, one independent filter per key.
  always_comb begin
`ifdef KEY_REPEAT_EN
    rep_seen_d = rep_seen_q;
`endif
    for (int i = 0; i < KEY_W; i++) begin
      state_d[i] = state_q[i];
      cnt_d[i]   = cnt_q[i];
      case (state_q[i])
        IDLE: begin
          if (p[i]) begin
            state_d[i] = PFILT;
            cnt_d[i]   = CNT_ONE;
          end
        end
        PFILT: begin
          if (!p[i]) begin
            state_d[i] = IDLE;
            cnt_d[i]   = '0;
          end else if (cnt_q[i] == DEB_LAST) begin
            state_d[i] = DOWN;
            cnt_d[i]   = '0;
          end else begin
            cnt_d[i] = cnt_q[i] + CNT_ONE;
          end
        end
        DOWN: begin
          if (!p[i]) begin
            state_d[i] = RFILT;
            cnt_d[i]   = CNT_ONE;
`ifdef KEY_REPEAT_EN
            rep_seen_d[i] = 1'b0;
          end else if (rep_hit[i]) begin
            // After the first pulse the same counter times the repeat interval.
            cnt_d[i]      = '0;
            rep_seen_d[i] = 1'b1;
          end else if (cnt_q[i] != CNT_TOP) begin
            cnt_d[i] = cnt_q[i] + CNT_ONE;
`endif
          end
        end
        RFILT: begin
          if (p[i]) begin
            state_d[i] = DOWN;
            cnt_d[i]   = '0;
          end else if (cnt_q[i] == DEB_LAST) begin
            state_d[i] = IDLE;
            cnt_d[i]   = '0;
          end else begin
            cnt_d[i] = cnt_q[i] + CNT_ONE;
          end
        end
        default: begin
          state_d[i] = IDLE;
          cnt_d[i]   = '0;
        end
      endcase
    end
  end

  // Output decode from current state; registered below.
  always_comb begin
    press_d   = '0;
    release_d = '0;
    level_d   = '0;
`ifdef KEY_REPEAT_EN
    rep_hit   = '0;
`endif
    for (int i = 0; i < KEY_W; i++) begin
      press_d[i]   = (state_q[i] == PFILT) && p[i] && (cnt_q[i] == DEB_LAST);
      release_d[i] = (state_q[i] == RFILT) && !p[i] && (cnt_q[i] == DEB_LAST);
      level_d[i]   = press_d[i] ||
                     (((state_q[i] == DOWN) || (state_q[i] == RFILT)) && !release_d[i]);
`ifdef KEY_REPEAT_EN
      rep_hit[i]   = (state_q[i] == DOWN) && p[i] &&
                     (cnt_q[i] == (rep_seen_q[i] ? RATE_LAST : DLY_LAST));
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      key_state   <= '0;
      key_press   <= '0;
      key_release <= '0;
    end else begin
      key_state   <= level_d;
      key_press   <= press_d;
      key_release <= release_d;
    end
  end

`ifdef KEY_REPEAT_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      rep_seen_q <= '0;
      key_repeat <= '0;
    end else begin
      rep_seen_q <= rep_seen_d;
      key_repeat <= rep_hit;
    end
  end
`else
  assign key_repeat = '0;
`endif

endmodule
